// File: rtl/sram_byte_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_byte_arbiter
// Purpose  : Arbitrates the CPU/chipset byte port and the video fetch port
//            onto one external 512 KB x 8 asynchronous SRAM. Generates the
//            read wait and write-enable pulse timing and returns one-cycle
//            done strobes with registered read data.
// Ports    : clk_100, reset          - clock, synchronous active-high reset
//            cpu_req/we/addr/wdata   - CPU request (level, held to cpu_done)
//            cpu_rdata, cpu_done     - CPU read data and completion pulse
//            vid_req/addr            - video read request (level)
//            vid_rdata, vid_done     - video read data and completion pulse
//            SRAM_ADDR, SRAM_DATA,
//            SRAM_WE_n               - board-side SRAM interface
// Options  : SRAM_ROUND_ROBIN_EN - when defined, simultaneous requests are
//            granted alternately (video wins the first tie after reset);
//            when undefined, video always has priority.
// Revision : 1.0 - initial release
// ============================================================================
module sram_byte_arbiter #(
  parameter int ADDR_W    = 19,
  parameter int RD_CYCLES = 2,
  parameter int WE_CYCLES = 2
) (
  input  logic              clk_100,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_done,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [7:0]        vid_rdata,
  output logic              vid_done,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [7:0]        SRAM_DATA,
  output logic              SRAM_WE_n
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_WAIT  = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // Read data is sampled in the cycle the counter equals RD_CYCLES; the
  // write pulse ends after WE_CYCLES clocks, counted from zero.
  localparam logic [3:0] RD_LAST = 4'(RD_CYCLES);
  localparam logic [3:0] WE_LAST = 4'(WE_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       gnt_vid;   // owner of the access in flight (1 = video)
  logic [7:0] wdata_q;
  logic       data_oe;
  logic       pick_vid;  // arbitration result used in IDLE

`ifdef SRAM_ROUND_ROBIN_EN
  logic last_vid;        // last port served (1 = video, reset = CPU)

  // On a tie the port that was not served last wins.
  always_comb begin
    pick_vid = vid_req && (!cpu_req || !last_vid);
  end
`else
  always_comb begin
    pick_vid = vid_req;
  end
`endif

  // The bus is only driven from WR_SETUP through WR_HOLD.
  assign SRAM_DATA = data_oe ? wdata_q : 8'bz;

  always_ff @(posedge clk_100) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      gnt_vid   <= 1'b0;
      wdata_q   <= '0;
      data_oe   <= 1'b0;
      SRAM_ADDR <= '0;
      SRAM_WE_n <= 1'b1;
      cpu_done  <= 1'b0;
      vid_done  <= 1'b0;
      cpu_rdata <= '0;
      vid_rdata <= '0;
`ifdef SRAM_ROUND_ROBIN_EN
      last_vid  <= 1'b0;
`endif
    end else begin
      cpu_done <= 1'b0;
      vid_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (pick_vid) begin
            gnt_vid   <= 1'b1;
            SRAM_ADDR <= vid_addr;
            state     <= ST_RD_WAIT;
`ifdef SRAM_ROUND_ROBIN_EN
            last_vid  <= 1'b1;
`endif
          end else if (cpu_req) begin
            gnt_vid   <= 1'b0;
            SRAM_ADDR <= cpu_addr;
            wdata_q   <= cpu_wdata;
`ifdef SRAM_ROUND_ROBIN_EN
            last_vid  <= 1'b0;
`endif
            if (cpu_we) begin
              data_oe <= 1'b1;
              state   <= ST_WR_SETUP;
            end else begin
              state   <= ST_RD_WAIT;
            end
          end
        end

        ST_RD_WAIT: begin
          if (cnt == RD_LAST) begin
            if (gnt_vid) vid_rdata <= SRAM_DATA;
            else         cpu_rdata <= SRAM_DATA;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        // Address and data have been settling for one clock with WE_n high.
        ST_WR_SETUP: begin
          SRAM_WE_n <= 1'b0;
          cnt       <= '0;
          state     <= ST_WR_PULSE;
        end

        ST_WR_PULSE: begin
          if (cnt == WE_LAST) begin
            SRAM_WE_n <= 1'b1;
            state     <= ST_WR_HOLD;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        // Data stays driven for one clock after WE_n rises (hold time).
        ST_WR_HOLD: begin
          data_oe <= 1'b0;
          state   <= ST_DONE;
        end

        // The done pulse is registered here, so it appears in the IDLE cycle
        // that follows; only the granted port is ever strobed.
        ST_DONE: begin
          if (gnt_vid) vid_done <= 1'b1;
          else         cpu_done <= 1'b1;
          state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_byte_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_byte_arbiter
// Purpose  : Self-checking bench for sram_byte_arbiter with a behavioural
//            asynchronous SRAM on the data bus and a shadow memory of the
//            bytes the bench has asked to be written.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_byte_arbiter;

  localparam int ADDR_W    = 19;
  localparam int RD_CYCLES = 2;
  localparam int WE_CYCLES = 2;
  // Negedges from raising a request while idle to seeing its done:
  // one grant edge plus the grant-to-done latency.
  localparam int RD_LAT = RD_CYCLES + 3;
  localparam int WR_LAT = WE_CYCLES + 4;
  localparam logic [7:0] BUS_IDLE = 8'hFF;   // pulled-up, undriven bus

  typedef logic [ADDR_W-1:0] addr_t;

  logic       clk_100   = 1'b0;
  logic       reset     = 1'b1;
  logic       cpu_req   = 1'b0;
  logic       cpu_we    = 1'b0;
  addr_t      cpu_addr  = '0;
  logic [7:0] cpu_wdata = '0;
  logic [7:0] cpu_rdata;
  logic       cpu_done;
  logic       vid_req   = 1'b0;
  addr_t      vid_addr  = '0;
  logic [7:0] vid_rdata;
  logic       vid_done;
  addr_t      SRAM_ADDR;
  wire  [7:0] SRAM_DATA;
  logic       SRAM_WE_n;

  int checks = 0;
  int passed = 0;
  bit exp_last_vid = 1'b0;

  // SRAM model
  bit   [7:0] mem_arr   [0:(1<<ADDR_W)-1];
  bit         mem_valid [0:(1<<ADDR_W)-1];
  logic [7:0] model_q   = '0;
  logic       mem_drive = 1'b0;
  logic [7:0] shadow [addr_t];

  sram_byte_arbiter #(
    .ADDR_W(ADDR_W), .RD_CYCLES(RD_CYCLES), .WE_CYCLES(WE_CYCLES)
  ) dut (
    .clk_100(clk_100), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .vid_req(vid_req), .vid_addr(vid_addr),
    .vid_rdata(vid_rdata), .vid_done(vid_done),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DATA(SRAM_DATA), .SRAM_WE_n(SRAM_WE_n)
  );

  always #5 clk_100 = ~clk_100;

  for (genvar b = 0; b < 8; b++) begin : g_pullup
    pullup (SRAM_DATA[b]);
  end

  assign SRAM_DATA = (mem_drive && SRAM_WE_n) ? model_q : 8'bz;

  function automatic logic [7:0] fill(input addr_t a);
    return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]} ^ 8'h5A;
  endfunction

  function automatic logic [7:0] mem_rd(input addr_t a);
    return mem_valid[a] ? mem_arr[a] : fill(a);
  endfunction

  function automatic logic [7:0] exp_rd(input addr_t a);
    if (shadow.exists(a)) return shadow[a];
    return fill(a);
  endfunction

  function automatic bit tie_goes_vid();
`ifdef SRAM_ROUND_ROBIN_EN
    return !exp_last_vid;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge clk_100) begin
    if (!SRAM_WE_n) begin
      mem_arr[SRAM_ADDR]   <= SRAM_DATA;
      mem_valid[SRAM_ADDR] <= 1'b1;
    end
  end

  always @(negedge clk_100) model_q <= mem_rd(SRAM_ADDR);

  // One request on one port, held until its done; called at a negedge.
  task automatic run_single(input bit is_vid, input bit we, input addr_t addr,
                            input logic [7:0] wd, output int cyc,
                            output logic [7:0] rd, output bit other_done);
    cyc = 0; other_done = 1'b0;
    mem_drive = !we;
    if (is_vid) begin
      vid_req = 1'b1; vid_addr = addr;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    end
    while (cyc < 60) begin
      @(negedge clk_100);
      cyc++;
      if (is_vid ? cpu_done : vid_done) other_done = 1'b1;
      if (is_vid ? vid_done : cpu_done) break;
    end
    rd = is_vid ? vid_rdata : cpu_rdata;
    vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic test_reset();
    addr_t a; int cyc; logic [7:0] rd; bit other;
    a = 19'h00ABC;
    reset = 1'b1; mem_drive = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_100);
      checks++;
      if (SRAM_WE_n !== 1'b1 || SRAM_DATA !== BUS_IDLE || cpu_done !== 1'b0 || vid_done !== 1'b0)
        $display("FAIL reset_hold c%0d: we_n=%b data=%h cpu_done=%b vid_done=%b, want 1/%h/0/0",
                 i, SRAM_WE_n, SRAM_DATA, cpu_done, vid_done, BUS_IDLE);
      else passed++;
    end
    checks++;
    if (SRAM_ADDR !== '0 || cpu_rdata !== 8'h00 || vid_rdata !== 8'h00)
      $display("FAIL reset_values: addr=%h cpu_rdata=%h vid_rdata=%h, want 0/00/00",
               SRAM_ADDR, cpu_rdata, vid_rdata);
    else passed++;
    reset = 1'b0; exp_last_vid = 1'b0;
    run_single(1'b0, 1'b0, a, 8'h00, cyc, rd, other);
    checks++;
    if (cyc != RD_LAT || other) $display("FAIL reset_first_grant: cycles=%0d other_done=%b, want %0d/0", cyc, other, RD_LAT);
    else passed++;
    checks++;
    if (rd !== exp_rd(a)) $display("FAIL reset_first_data: got %h want %h", rd, exp_rd(a));
    else passed++;
    exp_last_vid = 1'b0;
  endtask

  task automatic test_cpu_write();
    addr_t a; int cyc, lo; bit we_ok, addr_ok, data_ok, rel_ok;
    a = 19'h12345;
    mem_drive = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = 8'hA5;
    cyc = 0; lo = 0; we_ok = 1; addr_ok = 1; data_ok = 1; rel_ok = 1;
    while (cyc < 60) begin
      @(negedge clk_100);
      cyc++;
      if (!SRAM_WE_n) lo++;
      if (SRAM_WE_n !== !(cyc >= 2 && cyc <= WE_CYCLES + 1)) we_ok = 0;
      if (cyc <= WE_CYCLES + 2) begin
        if (SRAM_ADDR !== a) addr_ok = 0;
        if (SRAM_DATA !== 8'hA5) data_ok = 0;
      end
      if (cyc == WE_CYCLES + 3 && SRAM_DATA !== BUS_IDLE) rel_ok = 0;
      if (cpu_done) break;
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    shadow[a] = 8'hA5;
    checks++;
    if (cyc != WR_LAT) $display("FAIL write_latency: cycles=%0d want %0d", cyc, WR_LAT);
    else passed++;
    checks++;
    if (lo != WE_CYCLES || !we_ok) $display("FAIL write_we_pulse: low=%0d shape_ok=%b, want %0d/1", lo, we_ok, WE_CYCLES);
    else passed++;
    checks++;
    if (!addr_ok || !data_ok) $display("FAIL write_stable: addr_ok=%b data_ok=%b, want 1/1", addr_ok, data_ok);
    else passed++;
    checks++;
    if (!rel_ok) $display("FAIL write_release: bus still driven in done state, want %h", BUS_IDLE);
    else passed++;
    checks++;
    if (mem_rd(a) !== 8'hA5) $display("FAIL write_mem: sram holds %h want a5", mem_rd(a));
    else passed++;
    exp_last_vid = 1'b0;
  endtask

  task automatic test_cpu_read();
    int cyc; bit drv_ok, we_ok, other; logic [7:0] rd;
    // Read with the SRAM silent: the bus must stay at its pulled level.
    mem_drive = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h12345;
    cyc = 0; drv_ok = 1; we_ok = 1;
    while (cyc < 60) begin
      @(negedge clk_100);
      cyc++;
      if (SRAM_DATA !== BUS_IDLE) drv_ok = 0;
      if (SRAM_WE_n !== 1'b1) we_ok = 0;
      if (cpu_done) break;
    end
    cpu_req = 1'b0;
    checks++;
    if (!drv_ok || !we_ok || cyc != RD_LAT || cpu_rdata !== BUS_IDLE)
      $display("FAIL read_no_drive: bus_ok=%b we_ok=%b cycles=%0d rdata=%h, want 1/1/%0d/%h",
               drv_ok, we_ok, cyc, cpu_rdata, RD_LAT, BUS_IDLE);
    else passed++;
    run_single(1'b0, 1'b0, 19'h12345, 8'h00, cyc, rd, other);
    checks++;
    if (cyc != RD_LAT || rd !== 8'hA5) $display("FAIL read_back: cycles=%0d data=%h, want %0d/a5", cyc, rd, RD_LAT);
    else passed++;
    exp_last_vid = 1'b0;
    run_single(1'b1, 1'b0, 19'h00321, 8'h00, cyc, rd, other);
    checks++;
    if (cyc != RD_LAT || rd !== exp_rd(19'h00321) || other)
      $display("FAIL vid_read: cycles=%0d data=%h other=%b, want %0d/%h/0", cyc, rd, other, RD_LAT, exp_rd(19'h00321));
    else passed++;
    checks++;
    if (cpu_rdata !== 8'hA5) $display("FAIL cpu_rdata_hold: got %h want a5", cpu_rdata);
    else passed++;
    exp_last_vid = 1'b1;
  endtask

  task automatic test_collision();
    addr_t ca; int cyc, vcyc, ccyc; bit both, first_vid, other; logic [7:0] rd, vrd, crd;
    run_single(1'b0, 1'b1, 19'h7FFFF, 8'h3C, cyc, rd, other);
    shadow[19'h7FFFF] = 8'h3C;
    exp_last_vid = 1'b0;
    checks++;
    if (cyc != WR_LAT) $display("FAIL collision_preload: cycles=%0d want %0d", cyc, WR_LAT);
    else passed++;
    ca = 19'h01000 | addr_t'($urandom_range(0, 255));
    first_vid = tie_goes_vid();
    mem_drive = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ca;
    vid_req = 1'b1; vid_addr = 19'h7FFFF;
    cyc = 0; vcyc = 0; ccyc = 0; both = 0; vrd = '0; crd = '0;
    while (cyc < 100 && (vcyc == 0 || ccyc == 0)) begin
      @(negedge clk_100);
      cyc++;
      if (cpu_done && vid_done) both = 1;
      if (vid_done) begin vcyc = cyc; vrd = vid_rdata; vid_req = 1'b0; end
      if (cpu_done) begin ccyc = cyc; crd = cpu_rdata; cpu_req = 1'b0; end
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    checks++;
    if (both) $display("FAIL collision_overlap: both done strobes high together");
    else passed++;
    checks++;
    if (first_vid ? (vcyc != RD_LAT || ccyc != 2*RD_LAT) : (ccyc != RD_LAT || vcyc != 2*RD_LAT))
      $display("FAIL collision_order: vid_done@%0d cpu_done@%0d, video first=%b",
               vcyc, ccyc, first_vid);
    else passed++;
    checks++;
    if (vrd !== 8'h3C || crd !== exp_rd(ca))
      $display("FAIL collision_data: vid=%h cpu=%h, want 3c/%h", vrd, crd, exp_rd(ca));
    else passed++;
    exp_last_vid = !first_vid;
  endtask

  task automatic test_starvation();
    addr_t ca, va; int cyc, last, n; bit exp_vid;
    ca = 19'h02000 | addr_t'($urandom_range(0, 255));
    va = 19'h03000 | addr_t'($urandom_range(0, 255));
    mem_drive = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ca;
    vid_req = 1'b1; vid_addr = va;
    cyc = 0; last = 0; n = 0;
    while (n < 10 && cyc < 400) begin
      @(negedge clk_100);
      cyc++;
      if (cpu_done || vid_done) begin
        exp_vid = tie_goes_vid();
        checks++;
        if ((cpu_done && vid_done) || vid_done !== exp_vid || cyc - last != RD_LAT)
          $display("FAIL starve_grant %0d: vid_done=%b cpu_done=%b gap=%0d, want video=%b gap=%0d",
                   n, vid_done, cpu_done, cyc - last, exp_vid, RD_LAT);
        else passed++;
        checks++;
        if (vid_done ? (vid_rdata !== exp_rd(va)) : (cpu_rdata !== exp_rd(ca)))
          $display("FAIL starve_data %0d: vid=%h cpu=%h, want %h/%h", n, vid_rdata, cpu_rdata, exp_rd(va), exp_rd(ca));
        else passed++;
        exp_last_vid = exp_vid; last = cyc; n++;
      end
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    checks++;
    if (n != 10) $display("FAIL starve_timeout: %0d accesses completed, want 10", n);
    else passed++;
  endtask

  task automatic test_reset_mid_write();
    int cyc; bit seen, bus_ok;
    mem_drive = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h0F0F0; cpu_wdata = 8'h96;
    cyc = 0;
    while (cyc < 20 && SRAM_WE_n !== 1'b0) begin
      @(negedge clk_100);
      cyc++;
    end
    checks++;
    if (SRAM_WE_n !== 1'b0) $display("FAIL midwr_pulse: we_n=%b after %0d cycles, want 0", SRAM_WE_n, cyc);
    else passed++;
    reset = 1'b1;
    @(negedge clk_100);
    checks++;
    if (SRAM_WE_n !== 1'b1 || SRAM_DATA !== BUS_IDLE || cpu_done !== 1'b0)
      $display("FAIL midwr_abort: we_n=%b data=%h done=%b, want 1/%h/0", SRAM_WE_n, SRAM_DATA, cpu_done, BUS_IDLE);
    else passed++;
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk_100);
    reset = 1'b0; exp_last_vid = 1'b0;
    seen = 0; bus_ok = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_100);
      if (cpu_done || vid_done) seen = 1;
      if (SRAM_WE_n !== 1'b1 || SRAM_DATA !== BUS_IDLE) bus_ok = 0;
    end
    checks++;
    if (seen) $display("FAIL midwr_done: aborted write produced a done pulse, want none");
    else passed++;
    checks++;
    if (!bus_ok) $display("FAIL midwr_idle: bus or we_n active after abort, want idle");
    else passed++;
  endtask

  task automatic test_random();
    int kind, cyc; addr_t a; logic [7:0] wd, rd, exp; bit other;
    for (int i = 0; i < 30; i++) begin
      kind = int'($urandom_range(0, 2));
      a    = 19'h40000 | addr_t'($urandom_range(0, 15));
      wd   = 8'($urandom);
      if (kind == 0) begin
        run_single(1'b0, 1'b1, a, wd, cyc, rd, other);
        shadow[a] = wd;
        checks++;
        if (cyc != WR_LAT || other || mem_rd(a) !== wd)
          $display("FAIL rand_write %0d: addr=%h cycles=%0d other=%b sram=%h, want %0d/0/%h",
                   i, a, cyc, other, mem_rd(a), WR_LAT, wd);
        else passed++;
      end else begin
        exp = exp_rd(a);
        run_single(kind == 2, 1'b0, a, 8'h00, cyc, rd, other);
        checks++;
        if (cyc != RD_LAT || other || rd !== exp)
          $display("FAIL rand_read %0d: port=%0d addr=%h cycles=%0d other=%b data=%h, want %0d/0/%h",
                   i, kind, a, cyc, other, rd, RD_LAT, exp);
        else passed++;
      end
      exp_last_vid = (kind == 2);
      if ($urandom_range(0, 1) == 1) @(negedge clk_100);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_collision();
    test_starvation();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete, %0d/%0d so far", passed, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/sram_byte_arbiter.md
Name: sram_byte_arbiter

Overview:
- Sits between `system_512KB` and the board pins for the external 512 KB, 8-bit asynchronous SRAM.
- Arbitrates two byte-wide requesters, the CPU/chipset port and the video fetch port, onto a single SRAM_ADDR/SRAM_DATA/SRAM_WE_n interface.
- Generates the async-SRAM read and write timing with programmable wait cycles.
- Returns read data with a one-cycle done strobe.

Parameters:
- ADDR_W, 19, SRAM address width (512 KB).
- RD_CYCLES, 2, clocks the address is held before read data is sampled (1..15).
- WE_CYCLES, 2, clocks SRAM_WE_n is held low on a write (1..15).

Ports:
- clk_100  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU request; level, held until cpu_done.
- cpu_we  in  1  1 = write, 0 = read; sampled at grant.
- cpu_addr  in  ADDR_W  CPU byte address; sampled at grant.
- cpu_wdata  in  8  CPU write data; sampled at grant.
- cpu_rdata  out  8  CPU read data; valid in the cycle cpu_done is high, held until the next CPU read.
- cpu_done  out  1  one-cycle completion pulse.
- vid_req  in  1  video read request; level.
- vid_addr  in  ADDR_W  video byte address.
- vid_rdata  out  8  video read data, valid with vid_done.
- vid_done  out  1  one-cycle completion pulse.
- SRAM_ADDR  out  ADDR_W  SRAM address.
- SRAM_DATA  inout  8  SRAM data; driven only during writes, otherwise Z.
- SRAM_WE_n  out  1  SRAM write enable, active low.

Behaviour:
- Reset values:
  - SRAM_WE_n=1, SRAM_ADDR=0, SRAM_DATA=Z.
  - cpu_done=0, vid_done=0, cpu_rdata=0, vid_rdata=0.
  - FSM in IDLE, counter 0.
- FSM states: IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE:
  - If vid_req: grant video (fixed priority); latch vid_addr into SRAM_ADDR; go to RD_WAIT.
  - Else if cpu_req: grant CPU; latch addr/we/wdata.
    - cpu_we=0: go to RD_WAIT.
    - cpu_we=1: go to WR_SETUP.
- RD_WAIT:
  - Counter counts up to RD_CYCLES.
  - On the cycle it reaches RD_CYCLES, sample SRAM_DATA into the granted port's rdata register; go to DONE.
- WR_SETUP (1 clock):
  - Address and data are driven; WE_n stays 1.
  - Next state WR_PULSE.
- WR_PULSE:
  - WE_n=0 for exactly WE_CYCLES clocks; address and data are stable throughout.
  - Next state WR_HOLD.
- WR_HOLD (1 clock):
  - WE_n=1; data is still driven; address is unchanged.
  - Next state DONE.
- DONE:
  - Pulse the granted port's done for one clock; release the data bus.
  - Next state IDLE.
- A requester must see done and deassert req in the done cycle; a req still high in IDLE after done is treated as a new request.
- Latency:
  - Read grant to done = RD_CYCLES+2 clocks.
  - Write grant to done = WE_CYCLES+3 clocks.
- Every access returns to IDLE before the next one, so back-to-back grants have a 1-clock IDLE gap.
- Simultaneous cpu_req and vid_req in IDLE: video wins; the CPU waits.
- A request arriving mid-access is not serviced until IDLE; the in-flight access is never preempted.
- Reset mid-write:
  - WE_n goes to 1 and SRAM_DATA goes to Z in the cycle after reset is sampled.
  - The aborted access never produces done.
- Address bits above ADDR_W are not present; no wrap logic is required.
- The done outputs are never high for both ports in the same cycle.

Optional Feature:
- Macro: SRAM_ROUND_ROBIN_EN.
- Defined: arbitration alternates.
  - A last-grant flag records the last port served.
  - On a simultaneous request, the port not served last wins.
  - Reset value of last-grant = CPU, so video wins the first tie.
- Undefined: fixed video priority as described in Behaviour.

Test Plan:
- Reset: reset=1 for 3 clocks with cpu_req=1 -> SRAM_WE_n=1, SRAM_DATA=Z, no done pulse until 1 clock after reset falls; then normal grant.
- CPU write: cpu_we=1, addr 0x12345, data 0xA5 (RD_CYCLES=2, WE_CYCLES=2) -> WE_n low for exactly 2 clocks, address/data stable 1 clock before and after, cpu_done 5 clocks after grant; SRAM model holds 0xA5 at 0x12345.
- CPU read back: read 0x12345 -> cpu_rdata=0xA5 with cpu_done 4 clocks after grant; SRAM_DATA never driven.
- Collision: cpu_req and vid_req rise in the same IDLE cycle (vid_addr 0x7FFFF holds 0x3C) -> vid_done with 0x3C first, then cpu_done; the two dones are never simultaneous.
- Starvation check with SRAM_ROUND_ROBIN_EN: both ports hold req continuously for 10 accesses -> grants alternate V,C,V,C...; without the macro -> only video is served.
- Reset mid-write: assert reset during WR_PULSE -> WE_n=1 next clock, data bus Z, cpu_done never pulses.
